// File: rtl/prince_mask_pkg.sv
// Shared constants, FSM state type and PRINCE inverse S-box helpers for the
// second-order masked inverse S-box layer.
package prince_mask_pkg;

    localparam int NUM_SHARES = 3;
    localparam int NUM_SBOX   = 16;
    localparam int RAND_W     = 108;
    localparam int STATE_W    = 4 * NUM_SBOX;
    localparam int NUM_TERMS  = NUM_SHARES * NUM_SHARES * NUM_SHARES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_CAPT = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    // Nibble x holds S^-1(x).
    localparam logic [63:0] INV_SBOX_TABLE = 64'h1CE5_046A_98DF_237B;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [63:0] tab;
        tab = INV_SBOX_TABLE;
        return tab[4*x +: 4];
    endfunction

    function automatic logic [63:0] inv_sbox64(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Algebraic normal form of one output bit: bit m is the coefficient of the
    // monomial whose variables are the set bits of m (Moebius transform).
    function automatic logic [15:0] inv_sbox_anf(input int bit_idx);
        logic [15:0] f;
        logic [63:0] tab;
        tab = INV_SBOX_TABLE;
        f = '0;
        for (int x = 0; x < 16; x++) begin
            f[x] = tab[4*x + bit_idx];
        end
        for (int v = 0; v < 4; v++) begin
            for (int m = 0; m < 16; m++) begin
                if (((m >> v) & 1) == 1) begin
                    f[m] = f[m] ^ f[m ^ (1 << v)];
                end
            end
        end
        return f;
    endfunction

    localparam logic [15:0] INV_SBOX_ANF [4] = '{
        inv_sbox_anf(0), inv_sbox_anf(1), inv_sbox_anf(2), inv_sbox_anf(3)
    };

endpackage

// File: rtl/prince_inv_sbox_layer.sv
// Sixteen masked inverse S-box lanes with neighbour-share wiring; no control.
module prince_inv_sbox_layer
    import prince_mask_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel,
    input  logic [RAND_W-1:0]  rnd,
    input  logic [STATE_W-1:0] s1,
    input  logic [STATE_W-1:0] s2,
    input  logic [STATE_W-1:0] s3,
    output logic [STATE_W-1:0] o1,
    output logic [STATE_W-1:0] o2,
    output logic [STATE_W-1:0] o3
);

    for (genvar gi = 0; gi < NUM_SBOX; gi++) begin : g_lane
        localparam int NB = (gi + 1) % NUM_SBOX;
        prince_masked_inv_sbox u_sbox (
            .clk  (clk),
            .rst_n(rst_n),
            .in1  (s1[4*gi +: 4]),
            .in2  (s2[4*gi +: 4]),
            .in3  (s3[4*gi +: 4]),
            .nb   ({s2[4*NB +: 4], s1[4*NB +: 4]}),
            .r    (rnd),
            .sel  (sel),
            .out1 (o1[4*gi +: 4]),
            .out2 (o2[4*gi +: 4]),
            .out3 (o3[4*gi +: 4])
        );
    end

endmodule

// File: rtl/prince_masked_inv_sbox.sv
// One 3-share masked PRINCE inverse S-box: 27 registered cross-share component
// functions with ring-refreshed randomness, compressed back to 3 shares.
module prince_masked_inv_sbox
    import prince_mask_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        in1,
    input  logic [3:0]        in2,
    input  logic [3:0]        in3,
    input  logic [7:0]        nb,
    input  logic [RAND_W-1:0] r,
    input  logic              sel,
    output logic [3:0]        out1,
    output logic [3:0]        out2,
    output logic [3:0]        out3
);

    logic [3:0]        x_sh   [NUM_SHARES];
    logic [RAND_W-1:0] r_lane;
    logic [3:0]        comp_d [NUM_TERMS];
    logic [3:0]        comp_q [NUM_TERMS];
    logic [3:0]        out_sh [NUM_SHARES];

    assign x_sh[0] = in1;
    assign x_sh[1] = in2;
    assign x_sh[2] = in3;

    // Neighbour shares decorrelate lanes that otherwise see the same broadcast word.
    assign r_lane = r ^ {{(RAND_W-8){1'b0}}, (sel ? nb : 8'h00)};

    // Term t=(si,sj,sk) gathers every monomial cross product using share si of the
    // first variable, sj of the second, sk of the third; lower-degree products are
    // parked on the tuples with repeated trailing indices so each appears once.
    always_comb begin
        int   si, sj, sk, nv;
        int   v [3];
        logic acc;
        si  = 0;
        sj  = 0;
        sk  = 0;
        nv  = 0;
        v   = '{0, 0, 0};
        acc = 1'b0;
        for (int t = 0; t < NUM_TERMS; t++) begin
            comp_d[t] = '0;
        end
        for (int t = 0; t < NUM_TERMS; t++) begin
            si = t / 9;
            sj = (t / 3) % 3;
            sk = t % 3;
            for (int o = 0; o < 4; o++) begin
                acc = 1'b0;
                for (int m = 0; m < 16; m++) begin
                    if (INV_SBOX_ANF[o][m]) begin
                        nv = 0;
                        v  = '{0, 0, 0};
                        for (int b = 0; b < 4; b++) begin
                            if (((m >> b) & 1) == 1) begin
                                if (nv < 3) begin
                                    v[nv] = b;
                                end
                                nv = nv + 1;
                            end
                        end
                        case (nv)
                            0: if (t == 0) acc = acc ^ 1'b1;
                            1: if (si == sj && sj == sk) acc = acc ^ x_sh[si][v[0]];
                            2: if (sj == sk) acc = acc ^ (x_sh[si][v[0]] & x_sh[sj][v[1]]);
                            3: acc = acc ^ (x_sh[si][v[0]] & x_sh[sj][v[1]] & x_sh[sk][v[2]]);
                            default: ;
                        endcase
                    end
                end
                comp_d[t][o] = acc ^ r_lane[4*t + o] ^ r_lane[4*((t + 1) % NUM_TERMS) + o];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TERMS; t++) begin
                comp_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_TERMS; t++) begin
                comp_q[t] <= comp_d[t];
            end
        end
    end

    // The ring masks cancel over all 27 terms, so any 9/9/9 split is a valid sharing.
    always_comb begin
        for (int s = 0; s < NUM_SHARES; s++) begin
            out_sh[s] = '0;
        end
        for (int t = 0; t < NUM_TERMS; t++) begin
            out_sh[t / 9] = out_sh[t / 9] ^ comp_q[t];
        end
    end

    assign out1 = out_sh[0];
    assign out2 = out_sh[1];
    assign out3 = out_sh[2];

endmodule

// File: rtl/prince_inv_sbox_layer_ctrl.sv
// Handshake, operand/randomness holding and result capture around the masked
// inverse S-box layer.
module prince_inv_sbox_layer_ctrl
    import prince_mask_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_s1,
    input  logic [STATE_W-1:0] in_s2,
    input  logic [STATE_W-1:0] in_s3,
    input  logic [RAND_W-1:0]  rnd_in,
    input  logic               rnd_valid,
    output logic               rnd_ack,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_s1,
    output logic [STATE_W-1:0] out_s2,
    output logic [STATE_W-1:0] out_s3,
    output logic               sel_dbg
);

    state_e             state_q, state_d;
    logic [STATE_W-1:0] op_s1_q, op_s1_d, op_s2_q, op_s2_d, op_s3_q, op_s3_d;
    logic [STATE_W-1:0] out_s1_q, out_s1_d, out_s2_q, out_s2_d, out_s3_q, out_s3_d;
    logic [RAND_W-1:0]  rand_q, rand_d;
    logic               sel_q, sel_d;
    logic [STATE_W-1:0] lay_o1, lay_o2, lay_o3;
    logic               accept;

    // Gated by rst_n so nothing handshakes while reset is held.
    assign in_ready  = rst_n && !flush &&
                       (state_q == ST_IDLE || (state_q == ST_OUT && out_ready));
    assign accept    = in_valid && rnd_valid && in_ready;
    assign rnd_ack   = accept;
    assign out_valid = (state_q == ST_OUT) && !flush;
    assign out_s1    = out_s1_q;
    assign out_s2    = out_s2_q;
    assign out_s3    = out_s3_q;
    assign sel_dbg   = sel_q;

    prince_inv_sbox_layer u_layer (
        .clk  (clk),
        .rst_n(rst_n),
        .sel  (sel_q),
        .rnd  (rand_q),
        .s1   (op_s1_q),
        .s2   (op_s2_q),
        .s3   (op_s3_q),
        .o1   (lay_o1),
        .o2   (lay_o2),
        .o3   (lay_o3)
    );

    always_comb begin
        state_d  = state_q;
        op_s1_d  = op_s1_q;
        op_s2_d  = op_s2_q;
        op_s3_d  = op_s3_q;
        rand_d   = rand_q;
        sel_d    = sel_q;
        out_s1_d = out_s1_q;
        out_s2_d = out_s2_q;
        out_s3_d = out_s3_q;
        if (accept) begin
            op_s1_d = in_s1;
            op_s2_d = in_s2;
            op_s3_d = in_s3;
            rand_d  = rnd_in;
            sel_d   = ~sel_q;
        end
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EVAL;
            ST_EVAL: state_d = ST_CAPT;
            ST_CAPT: begin
                state_d = ST_OUT;
                if (!flush) begin
                    out_s1_d = lay_o1;
                    out_s2_d = lay_o2;
                    out_s3_d = lay_o3;
                end
            end
            ST_OUT: if (out_ready) state_d = accept ? ST_EVAL : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_s1_q  <= '0;
            op_s2_q  <= '0;
            op_s3_q  <= '0;
            rand_q   <= '0;
            sel_q    <= 1'b0;
            out_s1_q <= '0;
            out_s2_q <= '0;
            out_s3_q <= '0;
        end else begin
            state_q  <= state_d;
            op_s1_q  <= op_s1_d;
            op_s2_q  <= op_s2_d;
            op_s3_q  <= op_s3_d;
            rand_q   <= rand_d;
            sel_q    <= sel_d;
            out_s1_q <= out_s1_d;
            out_s2_q <= out_s2_d;
            out_s3_q <= out_s3_d;
        end
    end

endmodule

// File: tb/tb_prince_inv_sbox_layer_ctrl.sv
// Directed bench for the masked inverse S-box layer controller.
module tb_prince_inv_sbox_layer_ctrl;
    import prince_mask_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [STATE_W-1:0] in_s1 = '0, in_s2 = '0, in_s3 = '0;
    logic [RAND_W-1:0]  rnd_in = '0;
    logic               rnd_valid = 1'b0;
    logic               rnd_ack;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [STATE_W-1:0] out_s1, out_s2, out_s3;
    logic               sel_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] sv1, sv2, sv3, m2, m3;

    localparam logic [63:0] VEC_A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] EXP_A = 64'hB732_FD89_A640_5EC1;
    localparam logic [63:0] VEC_B = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] EXP_B = 64'h1CE5_046A_98DF_237B;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] EXP_F = 64'h1111_1111_1111_1111;
    localparam logic [63:0] EXP_0 = 64'hBBBB_BBBB_BBBB_BBBB;

    prince_inv_sbox_layer_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_s1    (in_s1),
        .in_s2    (in_s2),
        .in_s3    (in_s3),
        .rnd_in   (rnd_in),
        .rnd_valid(rnd_valid),
        .rnd_ack  (rnd_ack),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_s1   (out_s1),
        .out_s2   (out_s2),
        .out_s3   (out_s3),
        .sel_dbg  (sel_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [RAND_W-1:0] r108();
        logic [127:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom()};
        return w[RAND_W-1:0];
    endfunction

    task automatic start_txn(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        in_s1     = a;
        in_s2     = b;
        in_s3     = c;
        rnd_in    = r108();
        in_valid  = 1'b1;
        rnd_valid = 1'b1;
        #1;
    endtask

    // Called in the accepting cycle; returns in the first OUT cycle (or after the bound).
    task automatic finish_txn(input string tag, input logic [63:0] exp);
        int lat;
        chk({tag, ":rnd_ack"}, 64'(rnd_ack), 64'd1);
        tick();
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        #1;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        chk({tag, ":latency"}, 64'(lat), 64'd3);
        chk({tag, ":xor"}, out_s1 ^ out_s2 ^ out_s3, exp);
    endtask

    initial begin
        // Reset held: handshake outputs must be quiet even with valid inputs present.
        in_valid  = 1'b1;
        rnd_valid = 1'b1;
        #2;
        chk("rst:out_valid", 64'(out_valid), 64'd0);
        chk("rst:in_ready", 64'(in_ready), 64'd0);
        chk("rst:rnd_ack", 64'(rnd_ack), 64'd0);
        chk("rst:sel", 64'(sel_dbg), 64'd0);
        chk("rst:out_s1", out_s1, 64'd0);
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle:in_ready", 64'(in_ready), 64'd1);

        // 1: single unmasked-style transaction.
        chk("t1:sel_before", 64'(sel_dbg), 64'd0);
        start_txn(VEC_A, 64'd0, 64'd0);
        finish_txn("t1", EXP_A);
        chk("t1:sel_after", 64'(sel_dbg), 64'd1);
        tick();
        chk("t1:handshake_done", 64'(out_valid), 64'd0);

        // Reverse-ordered nibbles and a zero-valued sharing.
        m2 = r64();
        m3 = r64();
        start_txn(VEC_B ^ m2 ^ m3, m2, m3);
        finish_txn("vecB", EXP_B);
        tick();
        m2 = r64();
        m3 = r64();
        start_txn(m2 ^ m3, m2, m3);
        finish_txn("zero", EXP_0);
        tick();

        // 2: random masks over the all-ones state.
        for (int k = 0; k < 1000; k++) begin
            m2 = r64();
            m3 = r64();
            start_txn(ONES ^ m2 ^ m3, m2, m3);
            finish_txn("t2", EXP_F);
            tick();
        end

        // 3: backpressure with a pending input, then back-to-back accept.
        out_ready = 1'b0;
        m2 = r64();
        m3 = r64();
        start_txn(VEC_B ^ m2 ^ m3, m2, m3);
        finish_txn("t3a", EXP_B);
        sv1 = out_s1;
        sv2 = out_s2;
        sv3 = out_s3;
        m2 = r64();
        m3 = r64();
        start_txn(VEC_A ^ m2 ^ m3, m2, m3);
        for (int k = 0; k < 10; k++) begin
            chk("t3:out_valid", 64'(out_valid), 64'd1);
            chk("t3:hold_s1", out_s1, sv1);
            chk("t3:hold_s2", out_s2, sv2);
            chk("t3:hold_s3", out_s3, sv3);
            chk("t3:in_ready", 64'(in_ready), 64'd0);
            chk("t3:rnd_ack", 64'(rnd_ack), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t3:in_ready_rise", 64'(in_ready), 64'd1);
        finish_txn("t3b", EXP_A);
        tick();

        // 4: randomness starvation.
        in_s1     = VEC_B;
        in_s2     = '0;
        in_s3     = '0;
        in_valid  = 1'b1;
        rnd_valid = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("t4:rnd_ack", 64'(rnd_ack), 64'd0);
            chk("t4:idle", 64'(in_ready), 64'd1);
            chk("t4:out_valid", 64'(out_valid), 64'd0);
            tick();
        end
        start_txn(VEC_B, 64'd0, 64'd0);
        finish_txn("t4", EXP_B);
        sv1 = out_s1;
        tick();

        // 5: flush during CAPT discards the transaction; flush beats accept in IDLE.
        start_txn(VEC_A, r64(), 64'd0);
        chk("t5:acc", 64'(rnd_ack), 64'd1);
        tick();
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        tick();
        flush     = 1'b1;
        in_valid  = 1'b1;
        rnd_valid = 1'b1;
        #1;
        chk("t5:capt_out_valid", 64'(out_valid), 64'd0);
        chk("t5:capt_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("t5:idle_in_ready", 64'(in_ready), 64'd0);
        chk("t5:idle_rnd_ack", 64'(rnd_ack), 64'd0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("t5:no_out_valid", 64'(out_valid), 64'd0);
            chk("t5:old_out_s1", out_s1, sv1);
            tick();
        end
        m2 = r64();
        m3 = r64();
        start_txn(m2 ^ m3, m2, m3);
        finish_txn("t5", EXP_0);
        tick();

        // 6: asynchronous reset during EVAL.
        start_txn(VEC_B, 64'd0, 64'd0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6:out_valid", 64'(out_valid), 64'd0);
        chk("t6:in_ready", 64'(in_ready), 64'd0);
        chk("t6:rnd_ack", 64'(rnd_ack), 64'd0);
        chk("t6:sel", 64'(sel_dbg), 64'd0);
        chk("t6:out_s1", out_s1, 64'd0);
        tick();
        tick();
        chk("t6:held_out_valid", 64'(out_valid), 64'd0);
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        rst_n     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6:after_out_valid", 64'(out_valid), 64'd0);
        end
        chk("t6:sel_before", 64'(sel_dbg), 64'd0);
        start_txn(VEC_A, 64'd0, 64'd0);
        finish_txn("t6", EXP_A);
        chk("t6:sel_after", 64'(sel_dbg), 64'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
